// File: rtl/commit_trace_unit.sv
// Commit trace producer: encodes per-cycle commit events into 16-bit trace words,
// buffers them in a FIFO and appends a statistics record once halt is seen.
module commit_trace_unit #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write,
    input  logic [2:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        halt,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        overflow,
    output logic        done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {RUN, STATS, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    // Only the low 10 cycle bits ever reach a header, so the wrapping counter keeps just those.
    logic [9:0]    r_cycle;
    logic [15:0]   r_inst_cnt, r_ich_cnt, r_icr_cnt, r_dch_cnt, r_dcr_cnt;
    logic [2:0]    r_stats_idx;
    logic          r_overflow;

    logic [15:0] w_words [5];
    logic [2:0]  w_nwords, w_push_n;
    logic [AW:0] w_free;
    logic        w_pop, w_ovf_set, w_is_load, w_is_store, w_mem_rec;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        w_is_load   = mem_read;
        w_is_store  = mem_write & ~halt & ~mem_read;
        w_mem_rec   = w_is_load | w_is_store;
        w_nwords    = (w_mem_rec ? 3'd3 : 3'd0) + (reg_write ? 3'd2 : 3'd0);
        w_free      = FULL - r_count;
        w_pop       = (r_count != '0) & out_ready;
        w_push_n    = 3'd0;
        w_ovf_set   = 1'b0;
        w_state_nxt = r_state;
        for (int i = 0; i < 5; i++) w_words[i] = 16'h0000;
        case (r_state)
            RUN: begin
                // Memory record leads; the REG record lands in slots 0-1 or 3-4.
                w_words[0] = w_mem_rec ? {(w_is_load ? 3'b010 : 3'b011), 3'b000, r_cycle}
                                       : {3'b001, write_reg, r_cycle};
                w_words[1] = w_mem_rec ? mem_addr : write_data;
                w_words[2] = w_is_load ? mem_data_out : mem_data_in;
                w_words[3] = {3'b001, write_reg, r_cycle};
                w_words[4] = write_data;
                if ((AW+1)'(w_nwords) <= w_free) w_push_n = w_nwords;
                else                             w_ovf_set = 1'b1;
                if (halt) w_state_nxt = STATS;
            end
            STATS: begin
                case (r_stats_idx)
                    3'd0:    w_words[0] = {3'b100, 3'b000, r_cycle};
                    3'd1:    w_words[0] = r_inst_cnt;
                    3'd2:    w_words[0] = r_ich_cnt;
                    3'd3:    w_words[0] = r_icr_cnt;
                    3'd4:    w_words[0] = r_dch_cnt;
                    default: w_words[0] = r_dcr_cnt;
                endcase
                if (r_count != FULL) begin
                    w_push_n = 3'd1;
                    if (r_stats_idx == 3'd5) w_state_nxt = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cycle     <= '0;
            r_inst_cnt  <= '0;
            r_ich_cnt   <= '0;
            r_icr_cnt   <= '0;
            r_dch_cnt   <= '0;
            r_dcr_cnt   <= '0;
            r_stats_idx <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop);
            if (w_ovf_set) r_overflow <= 1'b1;
            if (r_state == RUN) begin
                r_cycle    <= r_cycle + 10'd1;
                r_inst_cnt <= sat_inc(r_inst_cnt, reg_write | (mem_write & ~halt) | halt);
                r_ich_cnt  <= sat_inc(r_ich_cnt, icache_hit);
                r_icr_cnt  <= sat_inc(r_icr_cnt, icache_req);
                r_dch_cnt  <= sat_inc(r_dch_cnt, dcache_hit);
                r_dcr_cnt  <= sat_inc(r_dcr_cnt, dcache_req);
            end
            if (r_state == STATS && w_push_n != 3'd0) r_stats_idx <= r_stats_idx + 3'd1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < w_push_n) r_mem[r_wr_ptr + AW'(i)] <= w_words[i];
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign overflow  = r_overflow;
    assign done      = (r_state == DONE) && !out_valid;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Scoreboard bench for commit_trace_unit: a behavioural model queues expected
// trace words as stimulus is driven; a negedge monitor pops them on each handshake.
module tb_commit_trace_unit;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_write, mem_read, mem_write, halt;
    logic [2:0]  write_reg;
    logic [15:0] write_data, mem_addr, mem_data_in, mem_data_out;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
    logic        out_valid, out_ready, overflow, done;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    commit_trace_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overflow(overflow), .done(done)
    );

    logic [15:0] sb [$];
    int          n_chk = 0;
    int          n_err = 0;

    int          m_cnt;
    logic [9:0]  m_cycle;
    logic [15:0] m_inst, m_ich, m_icr, m_dch, m_dcr;
    logic        m_ovf;
    bit          m_run;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %04h expected %04h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    task automatic clr_in();
        reg_write = 0; write_reg = 0; write_data = 0;
        mem_read = 0; mem_write = 0; mem_addr = 0; mem_data_in = 0; mem_data_out = 0;
        halt = 0; icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    endtask

    task automatic rand_strobes();
        icache_req = 1'($urandom_range(0, 1));
        icache_hit = 1'($urandom_range(0, 1));
        dcache_req = 1'($urandom_range(0, 1));
        dcache_hit = 1'($urandom_range(0, 1));
    endtask

    // One clock: model what the DUT will do at the next edge, then advance.
    task automatic step();
        logic [15:0] w [$];
        int  pop;
        bit  was_run;
        was_run = m_run;
        if (m_run) begin
            pop = (m_cnt != 0 && out_ready) ? 1 : 0;
            if (mem_read) begin
                w.push_back({3'b010, 3'b000, m_cycle}); w.push_back(mem_addr); w.push_back(mem_data_out);
            end else if (mem_write && !halt) begin
                w.push_back({3'b011, 3'b000, m_cycle}); w.push_back(mem_addr); w.push_back(mem_data_in);
            end
            if (reg_write) begin
                w.push_back({3'b001, write_reg, m_cycle}); w.push_back(write_data);
            end
            if (int'(w.size()) <= DEPTH - m_cnt) begin
                foreach (w[i]) sb.push_back(w[i]);
                m_cnt += int'(w.size());
            end else begin
                m_ovf = 1'b1;
            end
            m_cnt -= pop;
            m_inst  = sat(m_inst, reg_write | (mem_write & ~halt) | halt);
            m_ich   = sat(m_ich, icache_hit);
            m_icr   = sat(m_icr, icache_req);
            m_dch   = sat(m_dch, dcache_hit);
            m_dcr   = sat(m_dcr, dcache_req);
            m_cycle = m_cycle + 10'd1;
            if (halt) begin
                m_run = 0;
                sb.push_back({3'b100, 3'b000, m_cycle});
                sb.push_back(m_inst); sb.push_back(m_ich); sb.push_back(m_icr);
                sb.push_back(m_dch);  sb.push_back(m_dcr);
            end
        end
        @(posedge clk); #1;
        if (was_run) chk("valid", 16'(out_valid), 16'(m_cnt != 0));
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        clr_in();
        m_cnt = 0; m_cycle = 0; m_inst = 0; m_ich = 0; m_icr = 0; m_dch = 0; m_dcr = 0;
        m_ovf = 0; m_run = 1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        out_ready = 1'b1;
        clr_in();
        for (int i = 0; i < max_cycles && (sb.size() != 0 || out_valid); i++) step();
        chk("drain_left", 16'(sb.size()), 16'd0);
        chk("drain_valid", 16'(out_valid), 16'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && out_valid) chk("stall_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("extra_word", 16'(sb.size()), 16'd1);
                else                chk("word", out_data, sb.pop_front());
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    initial begin
        clr_in();
        out_ready = 1'b0;
        reset_dut();
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_ovf", 16'(overflow), 16'd0);
        chk("rst_done", 16'(done), 16'd0);

        // REG at cycle 5, then LOAD+REG at cycle 7
        out_ready = 1'b1;
        repeat (5) step();
        reg_write = 1; write_reg = 3'd3; write_data = 16'h1234;
        step(); clr_in();
        step();
        mem_read = 1; mem_addr = 16'h0040; mem_data_out = 16'hBEEF;
        reg_write = 1; write_reg = 3'd2; write_data = 16'hBEEF;
        step(); clr_in();
        drain(20);

        // Backpressure: two stores fit, third is dropped whole
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_write = 1; mem_addr = 16'h0100 + 16'(i); mem_data_in = 16'hA5A0 + 16'(i);
            step(); clr_in();
        end
        step();
        chk("ovf_before", 16'(overflow), 16'd0);
        mem_write = 1; mem_addr = 16'h0102; mem_data_in = 16'hA5A2;
        step(); clr_in();
        chk("ovf_set", 16'(overflow), 16'd1);
        repeat (3) step();
        drain(20);
        chk("ovf_sticky", 16'(overflow), 16'd1);

        // Halt with a same-cycle store after three instructions
        reset_dut();
        chk("ovf_cleared", 16'(overflow), 16'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_strobes();
            case (i)
                0: begin reg_write = 1; write_reg = 3'd1; write_data = 16'h1111; end
                1: begin mem_write = 1; mem_addr = 16'h0200; mem_data_in = 16'h2222; end
                default: begin reg_write = 1; write_reg = 3'd4; write_data = 16'h4444; end
            endcase
            step(); clr_in();
        end
        rand_strobes();
        halt = 1; mem_write = 1; mem_addr = 16'h0300; mem_data_in = 16'h3333;
        step(); clr_in();
        chk("done_early", 16'(done), 16'd0);
        for (int i = 0; i < 4; i++) begin
            rand_strobes(); reg_write = 1; write_reg = 3'd7; write_data = 16'hDEAD;
            step(); clr_in();
        end
        drain(40);
        chk("done_set", 16'(done), 16'd1);

        // Halt with the FIFO full and the consumer stalled
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reg_write = 1; write_reg = 3'(i); write_data = 16'h5000 + 16'(i);
            step(); clr_in();
        end
        halt = 1;
        step(); clr_in();
        repeat (5) step();
        chk("full_valid", 16'(out_valid), 16'd1);
        chk("full_done", 16'(done), 16'd0);
        drain(40);
        chk("full_done_set", 16'(done), 16'd1);

        // Reset while STATS words are pending
        reset_dut();
        out_ready = 1'b0;
        halt = 1;
        step(); clr_in();
        repeat (3) step();
        chk("pend_valid", 16'(out_valid), 16'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_data", out_data, 16'h0000);
        reset_dut();
        reg_write = 1; write_reg = 3'd5; write_data = 16'h5555;
        step(); clr_in();
        drain(10);
        chk("final_done", 16'(done), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
